cave_cache_ctrl: RTL and testbench
==================================

// Module: cave_cache_ctrl
// PURPOSE
//  Read-only direct-mapped cache controller that drives the 4-entry x 87-bit
//  cache entry memory through its R0 (registered read) and W0 (write) ports.
//  Serves 64-bit reads from a requester, fills lines on miss with one backend
//  read, and clears all entries after reset or flush. Sits between a sprite or
//  tile fetch unit (front end) and the SDRAM arbiter port (back end).
// PARAMETERS
//  ADDR_WIDTH  27  byte address width; tag = ADDR_WIDTH-5 = 22 bits
//  DATA_WIDTH  64  line/word width; entry = 1 + tag + DATA_WIDTH = 87 bits
//  (line count fixed at 4: index = addr[4:3], offset addr[2:0] ignored)
// PORTS
//  clock         in   1    single clock for all logic
//  reset_n       in   1    asynchronous, active-low reset
//  flush         in   1    pulse: invalidate all entries
//  in_rd         in   1    front-end read request
//  in_addr       in   27   front-end byte address
//  in_waitReq    out  1    1 = request not accepted this cycle
//  in_valid      out  1    1-cycle pulse, in_dout valid
//  in_dout       out  64   read data
//  out_rd        out  1    backend read request
//  out_addr      out  27   backend address, {tag,index,3'b000}
//  out_waitReq   in   1    backend stall; request accepted when 0
//  out_valid     in   1    backend read data valid
//  out_din       in   64   backend read data
//  mem_rd_en     out  1    entry memory R0_en
//  mem_rd_addr   out  2    entry memory R0_addr
//  mem_rd_data   in   87   entry memory R0_data {valid,tag,data}, 1-cycle latency
//  mem_wr_en     out  1    entry memory W0_en
//  mem_wr_addr   out  2    entry memory W0_addr
//  mem_wr_data   out  87   entry memory W0_data {valid,tag,data}
// BEHAVIOUR
//  Reset (async, reset_n=0): state INIT, init counter 0, flush_pend 0;
//   in_valid, out_rd, mem_rd_en 0; in_waitReq 1; in_dout, out_addr 0.
//  States: INIT, IDLE, LOOKUP, FILL, WAIT.
//  INIT: 4 cycles, mem_wr_en=1, mem_wr_addr=counter 0..3, mem_wr_data=0;
//   in_waitReq=1; after counter=3 -> IDLE. Entry memory has no reset; INIT
//   is the only way entries become invalid.
//  IDLE: in_waitReq=0. flush or flush_pend -> INIT (clears flush_pend; any
//   in_rd that cycle is not accepted, in_waitReq=1). Else in_rd: latch
//   in_addr, mem_rd_en=1, mem_rd_addr=in_addr[4:3] -> LOOKUP.
//  LOOKUP: in_waitReq=1. Hit = mem_rd_data[86] & tag==latched addr[26:5]:
//   in_valid=1, in_dout=mem_rd_data[63:0] -> IDLE. Miss -> FILL.
//  FILL: out_rd=1, out_addr={tag,index,3'b000} held stable until cycle with
//   out_waitReq=0 -> WAIT (out_rd drops next cycle).
//  WAIT: on out_valid: mem_wr_en=1, mem_wr_addr=index,
//   mem_wr_data={1'b1,tag,out_din}; in_valid=1, in_dout=out_din -> IDLE.
//  Latency: hit = 1 cycle request-accept to in_valid; miss = 2 + backend cycles.
//  flush in LOOKUP/FILL/WAIT sets flush_pend; current access completes normally
//   (including its line write), then INIT.
//  out_valid outside WAIT ignored. mem_rd_en/mem_wr_en never both 1 same cycle.
//  Same-line request right after fill reads the written entry (write lands
//   before the next R0 address is registered): must hit.
//  Eviction: miss overwrites the indexed line unconditionally (no dirty state).
//  Reset mid-fill: backend must share reset_n; stale out_valid not expected.
// TESTING
//  Reset release -> 4 cycles mem_wr_en, addr 0,1,2,3, data 0; in_waitReq=0 cycle 5.
//  Read 0x0000040 cold -> out_rd addr 0x0000040; out_din=0xDEAD_BEEF_0000_0001
//   -> in_valid with that data, entry 0 = {1,0x000002,data}.
//  Repeat read 0x0000047 -> hit: in_valid 1 cycle after accept, no out_rd.
//  Read 0x0000840 (same index 0, tag 0x000042) -> miss, refill, then 0x40 misses.
//  out_waitReq held 1 for 5 cycles in FILL -> out_rd/out_addr stable 5 cycles.
//  flush during WAIT -> fill completes, in_valid, then INIT; next 0x40 read misses.

Source files
------------

// File: rtl/cave_cache_ctrl.sv
// Read-only direct-mapped 4-line cache controller between a fetch front end and
// an SDRAM arbiter port; drives an external 4 x {valid,tag,data} entry memory.
module cave_cache_ctrl #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 64
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             in_rd,
    input  logic [ADDR_WIDTH-1:0]            in_addr,
    output logic                             in_waitReq,
    output logic                             in_valid,
    output logic [DATA_WIDTH-1:0]            in_dout,
    output logic                             out_rd,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    input  logic                             out_waitReq,
    input  logic                             out_valid,
    input  logic [DATA_WIDTH-1:0]            out_din,
    output logic                             mem_rd_en,
    output logic [1:0]                       mem_rd_addr,
    input  logic [DATA_WIDTH+ADDR_WIDTH-5:0] mem_rd_data,
    output logic                             mem_wr_en,
    output logic [1:0]                       mem_wr_addr,
    output logic [DATA_WIDTH+ADDR_WIDTH-5:0] mem_wr_data
);

    localparam int TAG_W   = ADDR_WIDTH - 5;
    localparam int ENTRY_W = 1 + TAG_W + DATA_WIDTH;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, FILL, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              init_cnt_q;
    logic                    flush_pend_q;
    logic [ADDR_WIDTH-4:0]   line_q;
    logic                    accept;
    logic [TAG_W-1:0]        tag;
    logic [1:0]              index;
    logic                    hit;

    // Byte offset within the 64-bit line is irrelevant to a line cache.
    logic unused_offset_bits;
    assign unused_offset_bits = ^in_addr[2:0];

    assign tag      = line_q[ADDR_WIDTH-4:2];
    assign index    = line_q[1:0];
    assign hit      = mem_rd_data[ENTRY_W-1] && (mem_rd_data[ENTRY_W-2:DATA_WIDTH] == tag);
    assign out_addr = {line_q, 3'b000};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            init_cnt_q   <= 2'd0;
            flush_pend_q <= 1'b0;
            line_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                init_cnt_q <= init_cnt_q + 2'd1;
            // A flush arriving mid-access is remembered and honoured back in IDLE.
            if (state_q == IDLE)
                flush_pend_q <= 1'b0;
            else if (flush && (state_q == LOOKUP || state_q == FILL || state_q == WAIT))
                flush_pend_q <= 1'b1;
            if (accept)
                line_q <= in_addr[ADDR_WIDTH-1:3];
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        in_waitReq  = 1'b1;
        in_valid    = 1'b0;
        in_dout     = '0;
        out_rd      = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = 2'd0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = index;
        mem_wr_data = '0;

        case (state_q)
            INIT: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = init_cnt_q;
                if (init_cnt_q == 2'd3)
                    state_d = IDLE;
            end
            IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d = INIT;
                end else begin
                    in_waitReq = 1'b0;
                    if (in_rd) begin
                        accept      = 1'b1;
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = in_addr[4:3];
                        state_d     = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (hit) begin
                    in_valid = 1'b1;
                    in_dout  = mem_rd_data[DATA_WIDTH-1:0];
                    state_d  = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                out_rd = 1'b1;
                if (!out_waitReq)
                    state_d = WAIT;
            end
            WAIT: begin
                if (out_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = {1'b1, tag, out_din};
                    in_valid    = 1'b1;
                    in_dout     = out_din;
                    state_d     = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

endmodule

// File: tb/tb_cave_cache_ctrl.sv
// Bench for cave_cache_ctrl: entry-memory model, directed reads with hand-computed
// expected data pushed to a scoreboard queue, and an in_valid monitor.
module tb_cave_cache_ctrl;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_rd;
    logic [26:0]  in_addr;
    logic         in_waitReq;
    logic         in_valid;
    logic [63:0]  in_dout;
    logic         out_rd;
    logic [26:0]  out_addr;
    logic         out_waitReq;
    logic         out_valid;
    logic [63:0]  out_din;
    logic         mem_rd_en;
    logic [1:0]   mem_rd_addr;
    logic [86:0]  mem_rd_data;
    logic         mem_wr_en;
    logic [1:0]   mem_wr_addr;
    logic [86:0]  mem_wr_data;

    logic [86:0]  mem [4];
    logic [63:0]  exp_q [$];
    int           tests = 0;
    int           failed = 0;

    cave_cache_ctrl dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_rd(in_rd), .in_addr(in_addr), .in_waitReq(in_waitReq),
        .in_valid(in_valid), .in_dout(in_dout),
        .out_rd(out_rd), .out_addr(out_addr), .out_waitReq(out_waitReq),
        .out_valid(out_valid), .out_din(out_din),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clock = ~clock;

    // Entry memory: no reset of its own, so it holds valid-looking garbage until
    // the controller clears it (tag 2 would alias address 0x40 on lines 0 and 3).
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++)
                mem[i] <= {1'b1, 22'h000002, 64'hBAD0_0000_0000_0000 | 64'(i)};
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
        if (mem_rd_en)
            mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every in_valid pulse must match the oldest expected word.
    always @(negedge clock) begin
        if (reset_n && in_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_in_valid: got data %0h, expected no response", in_dout);
            end else begin
                check("in_dout", in_dout, exp_q.pop_front());
            end
        end
        if (mem_rd_en && mem_wr_en) begin
            tests++;
            failed++;
            $display("FAIL mem_port_clash: got rd_en=1 wr_en=1, expected not both");
        end
    end

    task automatic request(input logic [26:0] a);
        int n;
        in_rd   = 1'b1;
        in_addr = a;
        n = 0;
        @(negedge clock);
        while (in_waitReq && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("accept", in_waitReq, 1'b0);
        check("rd_port", {mem_rd_en, mem_rd_addr}, {1'b1, a[4:3]});
        @(posedge clock); #1;
        in_rd = 1'b0;
    endtask

    task automatic expect_hit();
        @(negedge clock);
        check("hit_latency", in_valid, 1'b1);
        check("hit_no_out_rd", out_rd, 1'b0);
        @(posedge clock); #1;
    endtask

    task automatic serve_miss(input logic [26:0] a, input logic [63:0] data,
                              input int stall, input bit flush_in_wait);
        int n;
        out_waitReq = (stall > 0);
        n = 0;
        @(negedge clock);
        while (!out_rd && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("fill_out_rd", out_rd, 1'b1);
        check("fill_out_addr", out_addr, {a[26:3], 3'b000});
        if (stall > 0) begin
            for (int k = 1; k < stall; k++) begin
                @(negedge clock);
                check("stall_stable", {out_rd, out_addr}, {1'b1, a[26:3], 3'b000});
            end
            @(posedge clock); #1;
            out_waitReq = 1'b0;
            @(negedge clock);
            check("stall_release", {out_rd, out_addr}, {1'b1, a[26:3], 3'b000});
        end
        @(posedge clock); #1;
        flush = flush_in_wait;
        @(negedge clock);
        check("wait_out_rd_drop", out_rd, 1'b0);
        @(posedge clock); #1;
        flush     = 1'b0;
        out_valid = 1'b1;
        out_din   = data;
        @(negedge clock);
        check("fill_write", {mem_wr_en, mem_wr_addr, mem_wr_data},
              {1'b1, a[4:3], 1'b1, a[26:5], data});
        @(posedge clock); #1;
        out_valid = 1'b0;
        out_din   = '0;
    endtask

    task automatic expect_init();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("init_write", {mem_wr_en, mem_wr_addr, mem_wr_data, in_waitReq},
                  {1'b1, 2'(i), 87'd0, 1'b1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_rd       = 1'b0;
        in_addr     = '0;
        out_waitReq = 1'b0;
        out_valid   = 1'b0;
        out_din     = '0;

        repeat (3) @(negedge clock);
        check("reset_in_valid", in_valid, 1'b0);
        check("reset_out_rd", out_rd, 1'b0);
        check("reset_mem_rd_en", mem_rd_en, 1'b0);
        check("reset_in_waitReq", in_waitReq, 1'b1);
        check("reset_in_dout", in_dout, 64'd0);
        check("reset_out_addr", out_addr, 27'd0);

        @(posedge clock); #1;
        reset_n = 1'b1;
        expect_init();
        @(negedge clock);
        check("idle_after_init", in_waitReq, 1'b0);
        @(posedge clock); #1;

        // Cold miss on line 0, tag 2.
        exp_q.push_back(64'hDEAD_BEEF_0000_0001);
        request(27'h0000040);
        serve_miss(27'h0000040, 64'hDEAD_BEEF_0000_0001, 0, 1'b0);

        // Same line, different byte offset: hit.
        exp_q.push_back(64'hDEAD_BEEF_0000_0001);
        request(27'h0000047);
        expect_hit();

        // Conflicting tag 0x42 on line 0 with a 5-cycle backend stall.
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        request(27'h0000840);
        serve_miss(27'h0000840, 64'h0123_4567_89AB_CDEF, 5, 1'b0);

        // 0x40 was evicted: miss, then an immediate same-line hit.
        exp_q.push_back(64'hCAFE_F00D_0000_0003);
        request(27'h0000040);
        serve_miss(27'h0000040, 64'hCAFE_F00D_0000_0003, 0, 1'b0);
        exp_q.push_back(64'hCAFE_F00D_0000_0003);
        request(27'h0000044);
        expect_hit();

        // Line 3 must miss despite garbage that looks valid before clearing.
        exp_q.push_back(64'h5555_AAAA_0000_0004);
        request(27'h0000058);
        serve_miss(27'h0000058, 64'h5555_AAAA_0000_0004, 2, 1'b0);
        exp_q.push_back(64'h5555_AAAA_0000_0004);
        request(27'h000005F);
        expect_hit();

        // Flush during WAIT: fill completes, then a full clear.
        exp_q.push_back(64'h1111_2222_3333_0005);
        request(27'h0000018);
        serve_miss(27'h0000018, 64'h1111_2222_3333_0005, 0, 1'b1);
        @(negedge clock);
        check("flush_pend_block", in_waitReq, 1'b1);
        expect_init();
        @(posedge clock); #1;

        exp_q.push_back(64'h7777_0000_0000_0006);
        request(27'h0000040);
        serve_miss(27'h0000040, 64'h7777_0000_0000_0006, 0, 1'b0);

        // Flush in IDLE wins over a simultaneous read.
        flush   = 1'b1;
        in_rd   = 1'b1;
        in_addr = 27'h0000040;
        @(negedge clock);
        check("flush_idle_block", {in_waitReq, mem_rd_en}, {1'b1, 1'b0});
        @(posedge clock); #1;
        flush = 1'b0;
        in_rd = 1'b0;
        expect_init();

        // Stray backend data outside WAIT must be ignored.
        @(posedge clock); #1;
        out_valid = 1'b1;
        out_din   = 64'hFFFF_0000_FFFF_0000;
        repeat (3) @(posedge clock);
        #1;
        out_valid = 1'b0;
        out_din   = '0;

        exp_q.push_back(64'h8888_9999_0000_0007);
        request(27'h0000058);
        serve_miss(27'h0000058, 64'h8888_9999_0000_0007, 0, 1'b0);

        repeat (3) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
